// File: rtl/inst_encode_loader_if.sv
// Instruction-field stream in, IMEM write port out; the loader sits on the slave side.
// The bench or boot harness drives the fields through the master side.
interface inst_encode_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_fmt;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encode_loader.sv
// Packs decoded RV64I fields into 32-bit words and writes them to consecutive IMEM words.
// Write lands one cycle after accept; in_ready drops when full or finishing. IMM_RANGE_CHECK_EN rejects unfit immediates.
module inst_encode_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 finish,
    inst_encode_loader_if.slave  bus,
    output logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_vld_q, wr_vld_d;
    logic [31:0]       wr_dat_q, wr_dat_d;
    logic              err_q, err_d;

    logic [31:0] imm;
    logic [6:0]  opc;
    logic [31:0] word;
    logic        fmt_legal;
    logic        imm_ok;
    logic        accept;

    assign imm = bus.in_imm;

    always_comb begin
        opc       = 7'b0000000;
        fmt_legal = 1'b1;
        word      = 32'd0;
        imm_ok    = 1'b1;
        case (bus.in_fmt)
            4'd0:    opc = 7'b0000011;
            4'd1:    opc = 7'b0010011;
            4'd2:    opc = 7'b0011011;
            4'd3:    opc = 7'b1100111;
            4'd4:    opc = 7'b0100011;
            4'd5:    opc = 7'b0110011;
            4'd6:    opc = 7'b0111011;
            4'd7:    opc = 7'b1100011;
            4'd8:    opc = 7'b1101111;
            4'd9:    opc = 7'b0010111;
            4'd10:   opc = 7'b0110111;
            default: fmt_legal = 1'b0;
        endcase
        case (bus.in_fmt)
            4'd5, 4'd6:
                word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, opc};
            4'd0, 4'd1, 4'd2:
                word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opc};
            4'd3:
                word = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, opc};
            4'd4:
                word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], opc};
            4'd7:
                word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], opc};
            4'd8:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opc};
            4'd9, 4'd10:
                word = {imm[31:12], bus.in_rd, opc};
            default:
                word = 32'd0;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // Each check asks whether the immediate is the sign extension of its encodable bits.
        case (bus.in_fmt)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: imm_ok = (imm[31:11] == {21{imm[11]}});
            4'd7:                         imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            4'd8:                         imm_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            4'd9, 4'd10:                  imm_ok = (imm[11:0] == 12'd0);
            default:                      imm_ok = 1'b1;
        endcase
`endif
    end

    assign bus.in_ready = (state_q == S_RUN) && (count_q < DEPTH_C) && !finish;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE_C;
            wr_addr_q <= '0;
            count_q   <= '0;
            wr_vld_q  <= 1'b0;
            wr_dat_q  <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            wr_vld_q  <= wr_vld_d;
            wr_dat_q  <= wr_dat_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        wr_vld_d  = 1'b0;
        wr_dat_d  = wr_dat_q;
        wr_addr_d = wr_addr_q;

        // A restart rewinds the session; the in-flight write keeps its own latched address.
        if (start) begin
            ptr_d   = BASE_C;
            count_d = '0;
            err_d   = 1'b0;
        end

        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (start)       state_d = S_RUN;
                else if (finish) state_d = wr_vld_q ? S_DRAIN : S_DONE;
            end
            S_DRAIN: state_d = start ? S_RUN : S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (fmt_legal && imm_ok) begin
                wr_vld_d  = 1'b1;
                wr_dat_d  = word;
                wr_addr_d = ptr_d;
                ptr_d     = ptr_d + PTR_ONE;
                count_d   = count_d + CNT_ONE;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Reset is synchronous, so the strobe must be masked during the reset cycle itself.
    assign bus.imem_we    = wr_vld_q && !rst;
    assign bus.imem_addr  = wr_addr_q;
    assign bus.imem_wdata = wr_dat_q;

    assign count = count_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Instruction encoder and instruction-memory writer for the RV64I core.
- Accepts decoded instruction fields (format class, registers, funct fields, immediate) over a valid/ready stream.
- Packs each into a 32-bit RISC-V word and writes it into instruction memory at consecutive word addresses.
- Used by the test/boot harness to build programs in IMEM; it performs the inverse of the main opcode decoder.

Parameters:
- ADDR_W, 10, width of the IMEM word address.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 1024, maximum number of words written per session (DEPTH ≤ 2^ADDR_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a session.
- finish  in  1  one-cycle pulse; ends a session.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept fields this cycle.
- in_fmt  in  4  class code: 0 LOAD(0000011), 1 OPIMM(0010011), 2 OPIMM32(0011011), 3 JALR(1100111), 4 STORE(0100011), 5 OP(0110011), 6 OP32(0111011), 7 BRANCH(1100011), 8 JAL(1101111), 9 AUIPC(0010111), 10 LUI(0110111); 11-15 illegal.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R-type only).
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate; byte offset for B/J; full 32-bit value for U.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  session active.
- done  out  1  session closed (sticky until start or rst).
- err  out  1  sticky error flag.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: all outputs 0; state IDLE; write pointer ptr = BASE_ADDR.
- States:
  - IDLE: start → RUN; ptr = BASE_ADDR; count = 0; done = 0; err = 0.
  - RUN: busy = 1. finish → DRAIN, or → DONE directly if no write is pending.
  - DRAIN: completes a pending write, then → DONE.
  - DONE: done = 1; start → RUN (same clearing as from IDLE).
- in_ready:
  - Asserted only in RUN, with count < DEPTH and finish = 0.
  - Combinational from state and count; never depends on in_valid.
- Accept: in_valid & in_ready in cycle N.
  - Encoded word registered.
  - Cycle N+1: imem_we = 1, imem_addr = ptr, imem_wdata = word; then ptr += 1, count += 1.
  - Back-to-back accepts sustain one write per cycle.
- Encoding ({} MSB first; opc from in_fmt):
  - R (5, 6): {funct7, rs2, rs1, funct3, rd, opc}.
  - I (0, 1, 2, 3): {imm[11:0], rs1, funct3, rd, opc}; JALR forces funct3 = 000.
  - S (4): {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}.
  - B (7): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}.
  - U (9, 10): {imm[31:12], rd, opc}.
  - J (8): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}.
  - Fields unused by a format are ignored.
- Illegal in_fmt (11-15): handshake completes, no write, ptr/count unchanged, err = 1.
- Full: at count == DEPTH, in_ready = 0 and further valid inputs stall. ptr never wraps inside a session.
- Simultaneous start and finish: start wins. Start while in RUN restarts the session; a write pending from the prior cycle still completes at its old address.
- rst mid-write: write suppressed in the reset cycle; everything returns to reset values.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: an immediate that does not fit its format flags err and suppresses the write; ptr/count are not advanced. Limits:
  - I/S: signed 12-bit.
  - B: signed 13-bit, bit 0 = 0.
  - J: signed 21-bit, bit 0 = 0.
  - U: imm[11:0] = 0.
- Undefined: out-of-range immediates are silently truncated per the encoding above; err is raised only for illegal in_fmt.

Test Plan:
- start; addi x1,x0,5 (fmt1, f3=0, rd=1, rs1=0, imm=5) → next cycle imem_we=1, addr=0, wdata=0x00500093; count=1.
- sw x2,8(x1) (fmt4, f3=2, rs1=1, rs2=2, imm=8) then beq x1,x2,-4 (fmt7, imm=0xFFFFFFFC) back-to-back → 0x0020A423 @1, 0xFE208EE3 @2, consecutive cycles.
- jal x1,8 (fmt8) → 0x008000EF; lui x5,0x12345 (fmt10, imm=0x12345000) → 0x123452B7; then finish → done=1, busy=0, count=5.
- DEPTH=4 build: five valid inputs held → four writes at 0..3, in_ready low after the fourth, no fifth write.
- fmt=12 → handshake completes, no imem_we, err=1 until the next start; with IMM_RANGE_CHECK_EN, addi imm=4096 → err=1, no write.
- rst asserted in the cycle a write is due → imem_we=0 that cycle, count=0, IDLE afterwards.
